// File: rtl/rand_pkg.sv
// Shared state encoding and parameter helpers for the LFSR-driven uniform sampler.
// Pure declarations; no logic, no latency, no flow control.
package rand_pkg;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    CHECK   = 2'd1,
    REDUCE  = 2'd2,
    PRESENT = 2'd3
  } state_e;

  // Largest multiple of range that fits in width bits; words at or above it are biased.
  function automatic int unsigned calc_limit(input int unsigned width, input int unsigned range);
    return ((32'd1 << width) / range) * range;
  endfunction

  function automatic bit params_ok(input int unsigned width, input int unsigned range);
    return (width >= 2) && (width <= 16) && (range >= 2) && (range <= (32'd1 << width));
  endfunction

endpackage

// File: rtl/urem_seq.sv
// Sequential restoring remainder: dividend_i % DIVISOR, one quotient bit per cycle.
// Latency WIDTH cycles after start_i; done_o/rem_o are valid in the last step cycle.
// No backpressure: the caller must capture rem_o on the edge where done_o is high.
module urem_seq #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DIVISOR = 100
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  output logic             done_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0] DIV_W = (WIDTH + 1)'(DIVISOR);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_step;

  // rem_q < DIVISOR <= 2^WIDTH, so trial never exceeds WIDTH+1 bits.
  always_comb begin
    trial    = {rem_q, dvd_q[WIDTH-1]};
    fits     = (trial >= DIV_W);
    rem_step = fits ? WIDTH'(trial - DIV_W) : trial[WIDTH-1:0];
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    if (start_i) begin
      cnt_d = CW'(WIDTH);
      rem_d = '0;
      dvd_d = dividend_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      rem_d = rem_step;
      dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
    end
  end

  assign done_o = (cnt_q == CW'(1));
  assign rem_o  = rem_step;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      rem_q <= '0;
      dvd_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      dvd_q <= dvd_d;
    end
  end

endmodule

// File: rtl/lfsr_rand_sampler.sv
// Turns an LFSR bit stream into unbiased integers in [0, RANGE) via rejection sampling.
// Latency 2*WIDTH+1 edges from FILL to out_valid_o; each rejected word adds WIDTH+1.
// Holds out_data_o until out_ready_i; the LFSR is stalled (lfsr_en_o=0) meanwhile.
module lfsr_rand_sampler
  import rand_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned RANGE = 100
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             bit_i,
  output logic             lfsr_en_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [7:0]       reject_cnt_o
);

  localparam int unsigned   LIMIT    = calc_limit(WIDTH, RANGE);
  localparam int unsigned   CW       = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0] LIMIT_W = (WIDTH + 1)'(LIMIT);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  if (!params_ok(WIDTH, RANGE)) begin : g_bad_params
    $error("lfsr_rand_sampler: requires 2<=WIDTH<=16 and 2<=RANGE<=2**WIDTH");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [7:0]       rej_q, rej_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             shift_en;
  logic             reject;
  logic             urem_start;
  logic             urem_done;
  logic [WIDTH-1:0] urem_rem;

  // Gated by reset so no LFSR bit is consumed while the word is being discarded.
  assign shift_en   = (state_q == FILL) && en_i && !rst_i;
  assign reject     = ({1'b0, word_q} >= LIMIT_W);
  assign urem_start = (state_q == CHECK) && !reject;

  urem_seq #(
    .WIDTH  (WIDTH),
    .DIVISOR(RANGE)
  ) u_urem (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (urem_start),
    .dividend_i(word_q),
    .done_o    (urem_done),
    .rem_o     (urem_rem)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    rej_d   = rej_q;
    valid_d = valid_q;
    data_d  = data_q;
    unique case (state_q)
      FILL: begin
        if (shift_en) begin
          word_d = {word_q[WIDTH-2:0], bit_i};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) state_d = CHECK;
        end
      end
      CHECK: begin
        cnt_d = '0;
        if (reject) begin
          if (rej_q != 8'hFF) rej_d = rej_q + 8'd1;
          state_d = FILL;
        end else begin
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        if (urem_done) begin
          data_d  = urem_rem;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ready_i) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FILL;
      cnt_q   <= '0;
      word_q  <= '0;
      rej_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      rej_q   <= rej_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign lfsr_en_o    = shift_en;
  assign out_valid_o  = valid_q;
  assign out_data_o   = data_q;
  assign reject_cnt_o = rej_q;

endmodule

// File: tb/tb_lfsr_rand_sampler.sv
// Bench for lfsr_rand_sampler (WIDTH=8, RANGE=100): directed cases plus random traffic,
// compared every cycle against a timeline model of words, rejections and results.
module tb_lfsr_rand_sampler;

  localparam int WIDTH = 8;
  localparam int RANGE = 100;
  localparam int LIMIT = 200;

  logic       clk_i;
  logic       rst_i;
  logic       en_i;
  logic       bit_i;
  logic       lfsr_en_o;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [7:0] out_data_o;
  logic [7:0] reject_cnt_o;

  lfsr_rand_sampler #(.WIDTH(WIDTH), .RANGE(RANGE)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .bit_i       (bit_i),
    .lfsr_en_o   (lfsr_en_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .reject_cnt_o(reject_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int fails  = 0;
  bit took;
  bit bitq[$];

  // Model: bits collected, completed word timeline, visible outputs.
  int m_edge, m_nb, m_word, m_rel_edge, m_val_edge, m_val, m_data, m_rej;
  bit m_busy, m_rej_pend, m_acc_pend, m_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_nb = 0; m_word = 0; m_busy = 0; m_rej_pend = 0; m_acc_pend = 0;
    m_valid = 0; m_data = 0; m_rej = 0; m_rel_edge = 0; m_val_edge = 0; m_val = 0;
  endfunction

  // Called exactly at an active edge, with the inputs that were stable for that cycle.
  function automatic void model_step();
    bit take, xfer;
    if (rst_i) return;
    take = en_i && !m_busy;
    xfer = m_valid && out_ready_i;
    m_edge++;
    if (xfer) begin
      m_valid = 0;
      m_busy  = 0;
    end
    if (take) begin
      m_word = ((m_word << 1) | int'(bit_i)) & 255;
      m_nb++;
      if (m_nb == WIDTH) begin
        m_nb   = 0;
        m_busy = 1;
        if (m_word >= LIMIT) begin
          m_rej_pend = 1;
          m_rel_edge = m_edge + 1;
        end else begin
          m_acc_pend = 1;
          m_val_edge = m_edge + WIDTH + 1;
          m_val      = m_word % RANGE;
        end
      end
    end
    if (m_rej_pend && m_edge == m_rel_edge) begin
      m_rej_pend = 0;
      m_busy     = 0;
      if (m_rej < 255) m_rej++;
    end
    if (m_acc_pend && m_edge == m_val_edge) begin
      m_acc_pend = 0;
      m_valid    = 1;
      m_data     = m_val;
    end
  endfunction

  task automatic push(input logic [7:0] w);
    for (int b = 7; b >= 0; b--) bitq.push_back(w[b]);
  endtask

  // One clock: present the next stream bit, note whether it was taken, advance the model.
  task automatic cyc();
    @(negedge clk_i);
    bit_i = (bitq.size() > 0) ? bitq[0] : 1'($urandom);
    #1 took = lfsr_en_o;
    @(posedge clk_i);
    model_step();
    if (took && bitq.size() > 0) void'(bitq.pop_front());
    #1;
  endtask

  task automatic wait_valid(output int n, output int ne);
    n  = 0;
    ne = 0;
    while (out_valid_o !== 1'b1 && n < 200) begin
      cyc();
      n++;
      if (took) ne++;
    end
    if (n >= 200) check("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      #2;
      check("cmp_lfsr_en", lfsr_en_o, en_i && !m_busy && !rst_i);
      check("cmp_valid", out_valid_o, m_valid);
      check("cmp_data", out_data_o, m_data);
      check("cmp_rej", reject_cnt_o, m_rej);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, ne;
    rst_i = 1'b1; en_i = 1'b0; bit_i = 1'b0; out_ready_i = 1'b0;
    m_edge = 0;
    model_reset();
    repeat (3) cyc();
    check("rst_valid", out_valid_o, 0);
    check("rst_data", out_data_o, 0);
    check("rst_rej", reject_cnt_o, 0);
    check("rst_lfsr_en", lfsr_en_o, 0);
    rst_i = 1'b0;
    cyc();
    check("post_rst_valid", out_valid_o, 0);
    check("post_rst_lfsr_en", lfsr_en_o, 0);

    // Accepted word, latency and bit usage.
    en_i = 1'b1; out_ready_i = 1'b1;
    push(8'h2D);
    wait_valid(n, ne);
    check("t2_latency", n, 17);
    check("t2_en_cycles", ne, 8);
    check("t2_data", out_data_o, 45);
    check("t2_rej", reject_cnt_o, 0);
    check("t2_model_data", m_data, 45);

    // Rejected word followed by an accepted one.
    push(8'hFA); push(8'hC7);
    cyc();
    check("t2_xfer_valid", out_valid_o, 0);
    wait_valid(n, ne);
    check("t3_latency", n, 26);
    check("t3_en_cycles", ne, 16);
    check("t3_rej", reject_cnt_o, 1);
    check("t3_data", out_data_o, 99);
    check("t3_model_rej", m_rej, 1);

    // Backpressure holds the result and stalls the LFSR.
    push(8'h96);
    cyc();
    out_ready_i = 1'b0;
    wait_valid(n, ne);
    check("t4_latency", n, 17);
    check("t4_data", out_data_o, 50);
    repeat (5) begin
      cyc();
      check("t4_hold_valid", out_valid_o, 1);
      check("t4_hold_data", out_data_o, 50);
      check("t4_hold_lfsr_en", took, 0);
    end
    out_ready_i = 1'b1;
    cyc();
    check("t4_xfer_valid", out_valid_o, 0);

    // Pausing collection mid-word.
    push(8'h2D);
    repeat (3) begin cyc(); check("t5_taken", took, 1); end
    en_i = 1'b0;
    repeat (4) begin cyc(); check("t5_paused", took, 0); end
    en_i = 1'b1;
    wait_valid(n, ne);
    check("t5_latency", n, 14);
    check("t5_en_cycles", ne, 5);
    check("t5_data", out_data_o, 45);

    // Reset during the reduction discards the pending result.
    push(8'h42);
    cyc();
    repeat (12) cyc();
    rst_i = 1'b1;
    model_reset();
    #1;
    check("t6_rst_valid", out_valid_o, 0);
    check("t6_rst_data", out_data_o, 0);
    repeat (2) cyc();
    check("t6_rst_hold_valid", out_valid_o, 0);
    rst_i = 1'b0;
    bitq.delete();
    push(8'h05);
    wait_valid(n, ne);
    check("t6_latency", n, 17);
    check("t6_data", out_data_o, 5);
    check("t6_rej", reject_cnt_o, 0);

    // Random traffic against the model.
    cyc();
    for (int i = 0; i < 1500; i++) begin
      if (bitq.size() < 8) push(8'($urandom));
      en_i        = ($urandom_range(0, 9) < 8);
      out_ready_i = ($urandom_range(0, 9) < 6);
      cyc();
    end

    // Asynchronous reset between edges clears a held result immediately.
    en_i = 1'b1; out_ready_i = 1'b0;
    bitq.delete();
    wait_valid(n, ne);
    check("t7_valid_before_rst", out_valid_o, 1);
    #3 rst_i = 1'b1;
    model_reset();
    #1;
    check("t7_async_valid", out_valid_o, 0);
    check("t7_async_data", out_data_o, 0);
    check("t7_async_rej", reject_cnt_o, 0);
    check("t7_async_lfsr_en", lfsr_en_o, 0);
    cyc();
    rst_i = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
